bit_serial_alu_ctrl: RTL and testbench

BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

---
 rtl/bit_serial_alu_ctrl_if.sv | 25 ++
 rtl/bit_serial_alu_ctrl.sv | 138 +++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_alu_ctrl_if.sv
// rtl/bit_serial_alu_ctrl_if.sv - request/response bundle for the bit-serial ALU controller
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - one-bit ALU slice walked LSB-first over WIDTH cycles
module alu_bit_slice (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] c_i,
  output logic       f_o,
  output logic       cout_o
);
  logic bb;

  // c[0] selects ~B for SUB and the inverted-B logic ops
  assign bb     = c_i[0] ? ~b_i : b_i;
  assign cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);

  always_comb begin
    f_o = 1'b0;
    case (c_i[2:1])
      2'b00:   f_o = a_i ^ bb ^ cin_i;
      2'b01:   f_o = a_i | bb;
      2'b10:   f_o = a_i & bb;
      default: f_o = c_i[0] ? bb : ~a_i;
    endcase
  end
endmodule

module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bit_serial_alu_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             slice_f, slice_cout, arith;
  logic [WIDTH-1:0] sr_next;

  alu_bit_slice u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .c_i    (op_q),
    .f_o    (slice_f),
    .cout_o (slice_cout)
  );

  assign arith   = (op_q[2:1] == 2'b00);
  assign sr_next = {slice_f, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    sr_d     = sr_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          carry_d = bus.op[0];
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      RUN: begin
        sr_d    = sr_next;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q is still the carry into the MSB slice on this edge
          state_d  = DONE;
          result_d = sr_next;
          cout_d   = arith & slice_cout;
          ovf_d    = arith & (carry_q ^ slice_cout);
          zero_d   = (sr_next == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      sr_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb/tb_bit_serial_alu_ctrl.sv - directed vectors plus multi-cycle corner sequences
module tb_bit_serial_alu_ctrl;
  localparam int WIDTH = 8;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  bit_serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // word-level reference: {cout, ovf, zero, result}
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] bb, r;
    logic c, v;
    bb = op[0] ? ~b : b;
    c  = 1'b0;
    v  = 1'b0;
    r  = 8'h00;
    case (op)
      3'd0, 3'd1: begin
        s = {1'b0, a} + {1'b0, bb} + {8'h00, op[0]};
        r = s[7:0];
        c = s[8];
        v = (a[7] == bb[7]) && (r[7] != a[7]);
      end
      3'd2: r = a | b;
      3'd3: r = a | ~b;
      3'd4: r = a & b;
      3'd5: r = a & ~b;
      3'd6: r = ~a;
      default: r = ~b;
    endcase
    return {c, v, (r == 8'h00), r};
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [10:0] exp, input bit scramble);
    int  n;
    bit  got;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, " busy after accept"}, {31'd0, bus.busy}, 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      if (scramble) begin
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
        bus.op = 3'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
      if (bus.done) got = 1'b1;
    end
    check({name, " latency"}, 32'(n), 32'd8);
    check({name, " cvz_result"}, {21'd0, bus.cout, bus.ovf, bus.zero, bus.result}, {21'd0, exp});
    @(posedge clk);
    #1;
    check({name, " done one cycle"}, {31'd0, bus.done}, 32'd0);
  endtask

  vec_t     vecs[12];
  logic [2:0] op_h[64];
  logic [7:0] a_h[64];
  logic [7:0] b_h[64];

  initial begin
    int dones;
    int last_done;
    bit seen_done;

    vecs[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b101, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{3'b010, 8'h12, 8'h40, 8'h52, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 8'hF3, 8'h3E, 8'h32, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b110, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {20'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.result}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].r}, 1'b0);

    // operands and op changed every cycle after accept
    run_op("scramble", 3'b000, 8'h11, 8'h22, {3'b000, 8'h33}, 1'b1);

    // start held high with fresh random inputs each cycle
    dones     = 0;
    last_done = -1;
    op_h[0]   = 3'($urandom);
    a_h[0]    = 8'($urandom);
    b_h[0]    = 8'($urandom);
    bus.op    = op_h[0];
    bus.a     = a_h[0];
    bus.b     = b_h[0];
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dones++;
        if (cyc >= 8)
          check($sformatf("stream done@%0d", cyc),
                {21'd0, bus.cout, bus.ovf, bus.zero, bus.result},
                {21'd0, model(op_h[cyc-8], a_h[cyc-8], b_h[cyc-8])});
        if (last_done >= 0)
          check($sformatf("stream spacing@%0d", cyc), 32'(cyc - last_done), 32'd10);
        last_done = cyc;
      end
      op_h[cyc+1] = 3'($urandom);
      a_h[cyc+1]  = 8'($urandom);
      b_h[cyc+1]  = 8'($urandom);
      bus.op      = op_h[cyc+1];
      bus.a       = a_h[cyc+1];
      bus.b       = b_h[cyc+1];
    end
    bus.start = 1'b0;
    check("stream done count", 32'(dones), 32'd5);

    // reset asserted during the third RUN cycle
    bus.start = 1'b1;
    bus.op    = 3'b000;
    bus.a     = 8'h7F;
    bus.b     = 8'h7F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort outputs", {20'd0, bus.busy, bus.done, bus.cout, bus.ovf, bus.zero, bus.result}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    rst_n = 1'b1;
    run_op("post-reset add", 3'b000, 8'h01, 8'h02, {3'b000, 8'h03}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
